// File: rtl/reg8_mux_dff.sv
// Enabled parallel register built from WIDTH identical bit cells, each a 2:1
// hold/load mux feeding a flop, with an asynchronous active-high clear.
module reg8_mux_dff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,  // active-high despite the name
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_q;

  // Hold is a mux recirculating the flop output, so the clock always runs.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_mux[gi] = en ? d[gi] : r_q[gi];

      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
          r_q[gi] <= 1'b0;
        end else begin
          r_q[gi] <= w_mux[gi];
        end
      end
    end
  endgenerate

  assign q = r_q;

endmodule

// File: tb/tb_reg8_mux_dff.sv
// Directed plus randomised checks of load, hold, mid-cycle input changes and
// asynchronous clear for reg8_mux_dff, using an expected-value queue.
`timescale 1ns/1ps
module tb_reg8_mux_dff;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rstn;
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  int n_tests;
  int n_fail;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t sb[$];

  reg8_mux_dff #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .d    (d),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic goto(input longint t);
    longint now;
    now = longint'($time);
    if (t > now) #(t - now);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: q=%h expected an entry", q);
    end else begin
      e = sb.pop_front();
      assert (q === e.val) else begin
        n_fail++;
        $error("FAIL %s: q=%h expected %h at %0t", e.tag, q, e.val, $time);
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] exp_v;
    longint           e_t;

    n_tests = 0;
    n_fail  = 0;

    // Reset held from time zero.
    rstn = 1'b1; en = 1'b0; d = '0;
    push("reset_t1", 8'h00);        goto(1);  check();
    push("reset_edge5", 8'h00);     goto(6);  check();
    push("reset_t11", 8'h00);       goto(11); check();

    goto(12); rstn = 1'b0;
    push("release_hold15", 8'h00);  goto(16); check();

    goto(20); en = 1'b1; d = 8'hA5;
    push("load_A5", 8'hA5);         goto(26); check();

    goto(30); en = 1'b0; d = 8'h00;
    push("hold_A5_35", 8'hA5);      goto(36); check();
    push("hold_A5_45", 8'hA5);      goto(46); check();
    push("hold_A5_55", 8'hA5);      goto(56); check();

    goto(60); en = 1'b1; d = 8'h3C;
    push("load_3C", 8'h3C);         goto(66); check();
    push("reload_3C_75", 8'h3C);    goto(76); check();

    goto(80); en = 1'b0; d = 8'hFF;
    push("ignore_FF_85", 8'h3C);    goto(86); check();
    push("ignore_FF_95", 8'h3C);    goto(96); check();
    push("ignore_FF_101", 8'h3C);   goto(101); check();

    // Asynchronous clear between edges, then reset beats a pending load.
    goto(102); rstn = 1'b1;
    push("async_clear", 8'h00);     goto(103); check();
    en = 1'b1; d = 8'h5A;
    push("reset_over_en", 8'h00);   goto(106); check();

    goto(108); rstn = 1'b0; en = 1'b0;
    push("post_reset_hold", 8'h00); goto(116); check();

    goto(118); en = 1'b1; d = 8'h5A;
    push("post_reset_load", 8'h5A); goto(126); check();

    // Randomised back-to-back traffic with glitches injected after each edge.
    m_q = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      e_t = 135 + 10 * i;
      goto(e_t - 3);
      en = (i < 4) ? 1'b1 : 1'(($urandom % 2));
      d  = WIDTH'($urandom);
      exp_v = en ? d : m_q;
      push($sformatf("rand_edge_%0d", i), exp_v);
      goto(e_t + 1); check();
      goto(e_t + 2);
      en = ~en; d = ~d;
      push($sformatf("rand_glitch_%0d", i), exp_v);
      goto(e_t + 3); check();
      m_q = exp_v;
    end

    // All-ones load and clear, exercising every bit in both directions.
    goto(240); en = 1'b1; d = 8'hFF;
    push("load_FF", 8'hFF);         goto(246); check();
    goto(247); rstn = 1'b1;
    push("clear_FF", 8'h00);        goto(248); check();
    goto(250); rstn = 1'b0; en = 1'b0;
    push("final_hold", 8'h00);      goto(256); check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg8_mux_dff.md
REG8_MUX_DFF -- requirements
Module: reg8_mux_dff

Interface
REQ-001 Parameter: WIDTH, default 8, data path width in bits; all requirements below are stated for WIDTH=8 and SHALL scale to any WIDTH>=1.
REQ-002 Port: clk  input  1  single system clock; all state SHALL update on the rising edge only.
REQ-003 Port: rstn  input  1  reset; asynchronous and active-high (asserted when 1) despite the name.
REQ-004 Port: en  input  1  load enable; 1 = load d on the next rising clk edge, 0 = hold.
REQ-005 Port: d  input  WIDTH  parallel data in.
REQ-006 Port: q  output  WIDTH  registered data out, driven directly from the storage flops with no combinational path from any input.

Function
REQ-007 Each bit i SHALL be a 2:1 mux feeding a D flip-flop: mux output = en ? d[i] : q[i]; flop captures the mux output on rising clk.
REQ-008 The block SHALL be structured as WIDTH identical bit cells (mux + flop), instantiated via generate or explicit instances; no clock gating SHALL be used to implement hold.
REQ-009 Load latency SHALL be one clock: d sampled at rising edge N with en=1 SHALL appear on q immediately after edge N.
REQ-010 With en=0 at a rising edge, q SHALL retain its previous value; any d value, including all-ones, SHALL be ignored.
REQ-011 en and d SHALL be sampled only at rising clk edges; changes between edges SHALL NOT affect q.
REQ-012 All WIDTH bits SHALL load or hold together; no partial update.
REQ-013 Back-to-back loads (en=1 on consecutive edges) SHALL capture a new d every cycle.

Reset
REQ-014 While rstn=1, q SHALL be 8'h00 (all zeros for any WIDTH), regardless of clk, en, or d.
REQ-015 Assertion of rstn SHALL clear q asynchronously, without waiting for a clock edge, including mid-operation after earlier loads.
REQ-016 Reset SHALL take priority over en when both are active at a rising edge.
REQ-017 After rstn falls to 0, the first rising clk edge SHALL operate normally: load if en=1, hold 8'h00 if en=0.
REQ-018 q SHALL never be X after reset has been asserted once.

Verification
REQ-019 Bench uses a 10 ns clock (rising edges at 5, 15, 25, ... ns) and dumps waveforms of all ports.
REQ-020 Reset: rstn=1, en=0, d=8'h00 from t=0 to 12 ns -> q=8'h00 throughout; rstn=0 at 12 ns with en=0 -> q stays 8'h00 at the 15 ns edge.
REQ-021 Load: en=1, d=8'hA5 at 20 ns -> q=8'hA5 after the 25 ns edge.
REQ-022 Hold: en=0, d=8'h00 at 30 ns through 60 ns -> q stays 8'hA5 across the 35-55 ns edges.
REQ-023 Reload then ignore: en=1, d=8'h3C at 60 ns -> q=8'h3C after the 65 ns edge; en=0, d=8'hFF at 80 ns -> q stays 8'h3C through 100 ns.
REQ-024 Async reset mid-operation: with q=8'h3C, pulse rstn=1 between clock edges -> q=8'h00 immediately, before the next edge; rstn=1 with en=1, d=8'h5A at an edge -> q stays 8'h00.
